// File: rtl/td4_exec_core_if.sv
// Program-memory fetch port for td4_exec_core.
// Core is master: it requests an address, memory returns a word.
interface td4_exec_core_if #(
  parameter int WIDTH    = 4,
  parameter int PC_WIDTH = 4
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                valid;
  logic [WIDTH+3:0]    data;

  modport master (
    output req, addr,
    input  valid, data
  );

  modport slave (
    input  req, addr,
    output valid, data
  );
endinterface

// File: rtl/td4_exec_core.sv
// Registered TD4 execute core: fetch/exec/halt FSM with
// A, B, OUT, PC and carry, one commit per EXEC cycle.
module td4_exec_core #(
  parameter int WIDTH    = 4,
  parameter int PC_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  td4_exec_core_if.master  imem,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             out_strobe,
  input  logic             halt,
  output logic             halted,
  output logic             illegal,
  output logic             carry,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state;
  logic                req_q;
  logic [PC_WIDTH-1:0] pc;
  logic [WIDTH+3:0]    ir;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;

  logic [3:0]          op;
  logic [WIDTH-1:0]    imm;
  logic [WIDTH:0]      sum_a;
  logic [WIDTH:0]      sum_b;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jtgt;

  logic op_add_a, op_mov_ab, op_in_a, op_mov_ai;
  logic op_mov_ba, op_add_b, op_in_b, op_mov_bi;
  logic op_out_b, op_out_i, op_jnc, op_jmp;

  assign imem.req  = req_q;
  assign imem.addr = pc;
  assign reg_a     = a;
  assign reg_b     = b;

  assign op     = ir[WIDTH+3:WIDTH];
  assign imm    = ir[WIDTH-1:0];
  assign sum_a  = {1'b0, a} + {1'b0, imm};
  assign sum_b  = {1'b0, b} + {1'b0, imm};
  assign pc_inc = pc + 1'b1;
  assign jtgt   = imm[PC_WIDTH-1:0];

  assign op_add_a  = (op == 4'b0000);
  assign op_mov_ab = (op == 4'b0001);
  assign op_in_a   = (op == 4'b0010);
  assign op_mov_ai = (op == 4'b0011);
  assign op_mov_ba = (op == 4'b0100);
  assign op_add_b  = (op == 4'b0101);
  assign op_in_b   = (op == 4'b0110);
  assign op_mov_bi = (op == 4'b0111);
  assign op_out_b  = (op == 4'b1001);
  assign op_out_i  = (op == 4'b1011);
  assign op_jnc    = (op == 4'b1110);
  assign op_jmp    = (op == 4'b1111);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      req_q      <= 1'b1;
      halted     <= 1'b0;
      pc         <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      out_port   <= '0;
      carry      <= 1'b0;
      out_strobe <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      illegal    <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (imem.valid) begin
            ir    <= imem.data;
            state <= S_EXEC;
            req_q <= 1'b0;
          end else if (halt) begin
            state  <= S_HALT;
            req_q  <= 1'b0;
            halted <= 1'b1;
          end
        end
        S_EXEC: begin
          pc <= pc_inc;
          unique case (1'b1)
            op_add_a: begin
              a     <= sum_a[WIDTH-1:0];
              carry <= sum_a[WIDTH];
            end
            op_mov_ab: begin
              a     <= b;
              carry <= 1'b0;
            end
            op_in_a: begin
              a     <= in_port;
              carry <= 1'b0;
            end
            op_mov_ai: begin
              a     <= imm;
              carry <= 1'b0;
            end
            op_mov_ba: begin
              b     <= a;
              carry <= 1'b0;
            end
            op_add_b: begin
              b     <= sum_b[WIDTH-1:0];
              carry <= sum_b[WIDTH];
            end
            op_in_b: begin
              b     <= in_port;
              carry <= 1'b0;
            end
            op_mov_bi: begin
              b     <= imm;
              carry <= 1'b0;
            end
            op_out_b: begin
              out_port   <= b;
              out_strobe <= 1'b1;
              carry      <= 1'b0;
            end
            op_out_i: begin
              out_port   <= imm;
              out_strobe <= 1'b1;
              carry      <= 1'b0;
            end
            // JNC tests the carry held before this commit
            op_jnc: begin
              pc    <= carry ? pc_inc : jtgt;
              carry <= 1'b0;
            end
            op_jmp: begin
              pc    <= jtgt;
              carry <= 1'b0;
            end
            default: illegal <= 1'b1;
          endcase
          state  <= halt ? S_HALT : S_FETCH;
          req_q  <= !halt;
          halted <= halt;
        end
        S_HALT: begin
          if (!halt) begin
            state  <= S_FETCH;
            req_q  <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_FETCH;
          req_q  <= 1'b1;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4_exec_core.sv
// Bench for td4_exec_core: ISA-level model for WIDTH=4,
// directed literal checks for WIDTH=4 and WIDTH=8.
module tb_td4_exec_core;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- WIDTH=4 instance ----------------
  td4_exec_core_if #(.WIDTH(4), .PC_WIDTH(4)) bus4 ();
  logic       rst4, halt4, halted4, ill4, c4, strb4;
  logic [3:0] in4, out4, a4, b4;
  logic [7:0] prog4 [16];

  assign bus4.data = prog4[bus4.addr];

  td4_exec_core #(.WIDTH(4), .PC_WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst4),
    .imem       (bus4),
    .in_port    (in4),
    .out_port   (out4),
    .out_strobe (strb4),
    .halt       (halt4),
    .halted     (halted4),
    .illegal    (ill4),
    .carry      (c4),
    .reg_a      (a4),
    .reg_b      (b4)
  );

  // ---------------- WIDTH=8 instance ----------------
  td4_exec_core_if #(.WIDTH(8), .PC_WIDTH(8)) bus8 ();
  logic        rst8, halt8, halted8, ill8, c8, strb8;
  logic [7:0]  in8, out8, a8, b8;
  logic [11:0] prog8 [256];

  assign bus8.data = prog8[bus8.addr];

  td4_exec_core #(.WIDTH(8), .PC_WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst8),
    .imem       (bus8),
    .in_port    (in8),
    .out_port   (out8),
    .out_strobe (strb8),
    .halt       (halt8),
    .halted     (halted8),
    .illegal    (ill8),
    .carry      (c8),
    .reg_a      (a8),
    .reg_b      (b8)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // ISA-level model of the WIDTH=4 core.
  // phase: 0 waiting for a word, 1 word held for commit, 2 stopped
  int       mph, ma, mb, mo, mc, mpc;
  bit       ms, mil, mon;
  bit [7:0] mir;

  task automatic model_exec();
    int op, im, t, nxt;
    op  = int'(mir[7:4]);
    im  = int'(mir[3:0]);
    nxt = (mpc + 1) % 16;
    case (op)
      0:  begin t = ma + im; ma = t % 16; mc = t / 16; end
      1:  ma = mb;
      2:  ma = int'(in4);
      3:  ma = im;
      4:  mb = ma;
      5:  begin t = mb + im; mb = t % 16; mc = t / 16; end
      6:  mb = int'(in4);
      7:  mb = im;
      9:  begin mo = mb; ms = 1; end
      11: begin mo = im; ms = 1; end
      14: if (mc == 0) nxt = im;
      15: nxt = im;
      default: mil = 1;
    endcase
    if (!mil && op != 0 && op != 5) mc = 0;
    mpc = nxt;
  endtask

  initial begin
    mon = 0;
    forever begin
      @(posedge clk);
      if (!rst4) begin
        mph = 0; ma = 0; mb = 0; mo = 0; mc = 0; mpc = 0;
        ms = 0; mil = 0; mon = 1;
      end else begin
        ms  = 0;
        mil = 0;
        if (mph == 0) begin
          if (bus4.valid) begin
            mir = prog4[mpc];
            mph = 1;
          end else if (halt4) begin
            mph = 2;
          end
        end else if (mph == 1) begin
          model_exec();
          mph = halt4 ? 2 : 0;
        end else if (!halt4) begin
          mph = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon) begin
        chk("req",     32'(bus4.req), 32'(mph == 0));
        chk("halted",  32'(halted4),  32'(mph == 2));
        chk("addr",    32'(bus4.addr), mpc);
        chk("reg_a",   32'(a4),   ma);
        chk("reg_b",   32'(b4),   mb);
        chk("out",     32'(out4), mo);
        chk("carry",   32'(c4),   mc);
        chk("strobe",  32'(strb4), 32'(ms));
        chk("illegal", 32'(ill4),  32'(mil));
      end
    end
  end

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst4 = 0; halt4 = 0; in4 = 0; bus4.valid = 0;
    rst8 = 0; halt8 = 0; in8 = 0; bus8.valid = 0;
    for (int i = 0; i < 16; i++) prog4[i] = 8'h00;
    for (int i = 0; i < 256; i++) prog8[i] = 12'h000;
    prog4[0]  = 8'h3C;
    prog4[1]  = 8'h01;
    prog4[2]  = 8'h3F;
    prog4[3]  = 8'h01;
    prog4[4]  = 8'hE7;
    prog4[5]  = 8'hE7;
    prog4[7]  = 8'hB5;
    prog4[8]  = 8'h60;
    prog4[9]  = 8'h10;
    prog4[10] = 8'h80;
    prog4[11] = 8'hFD;
    prog4[13] = 8'h03;

    steps(2);
    chk("rst_req",  32'(bus4.req), 1);
    chk("rst_pc",   32'(bus4.addr), 0);
    chk("rst_a",    32'(a4), 0);
    chk("rst_halt", 32'(halted4), 0);
    rst4 = 1; bus4.valid = 1; in4 = 4'h9;

    steps(2); chk("movA_C", 32'(a4), 32'hC);
    steps(2); chk("addA1",  32'(a4), 32'hD);
              chk("addA1c", 32'(c4), 0);
    steps(2); chk("movA_F", 32'(a4), 32'hF);
    steps(2); chk("wrapA",  32'(a4), 0);
              chk("wrapc",  32'(c4), 1);
    steps(2); chk("jnc_c1pc", 32'(bus4.addr), 5);
              chk("jnc_c1c",  32'(c4), 0);
    steps(2); chk("jnc_c0pc", 32'(bus4.addr), 7);
    steps(2); chk("out5",    32'(out4), 5);
              chk("out5stb", 32'(strb4), 1);
    steps(1); chk("stb_off", 32'(strb4), 0);
    steps(1); chk("inB",     32'(b4), 9);
              chk("inBc",    32'(c4), 0);
    steps(2); chk("movAB",   32'(a4), 9);
    steps(2); chk("ill_p",   32'(ill4), 1);
              chk("ill_pc",  32'(bus4.addr), 11);
              chk("ill_a",   32'(a4), 9);
              chk("ill_out", 32'(out4), 5);

    bus4.valid = 0; halt4 = 1;
    steps(1); chk("h_halted", 32'(halted4), 1);
              chk("h_req",    32'(bus4.req), 0);
              chk("h_pc",     32'(bus4.addr), 11);
    halt4 = 0; bus4.valid = 1;
    steps(1); chk("h_resume", 32'(bus4.req), 1);
              chk("h_rpc",    32'(bus4.addr), 11);
    halt4 = 1;
    steps(1); chk("hv_exec",  32'(halted4), 0);
    steps(1); chk("hv_halt",  32'(halted4), 1);
              chk("hv_pc",    32'(bus4.addr), 13);
    halt4 = 0;
    steps(1); chk("hv_fetch", 32'(bus4.req), 1);
    steps(1);
    rst4 = 0; bus4.valid = 0;
    steps(1); chk("rx_a",   32'(a4), 0);
              chk("rx_pc",  32'(bus4.addr), 0);
              chk("rx_stb", 32'(strb4), 0);
    rst4 = 1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0)
        for (int i = 0; i < 16; i++) prog4[i] = 8'($urandom);
      bus4.valid = ($urandom_range(0, 3) != 0);
      in4        = 4'($urandom);
      if (halt4) halt4 = ($urandom_range(0, 3) != 0);
      else       halt4 = ($urandom_range(0, 25) == 0);
      rst4       = ($urandom_range(0, 300) != 0);
      steps(1);
    end
    rst4 = 1; halt4 = 0; bus4.valid = 1;

    prog8[8'h00] = 12'h7FF;
    prog8[8'h01] = 12'h501;
    prog8[8'h02] = 12'hFA5;
    prog8[8'hA5] = 12'hFFF;
    prog8[8'hFF] = 12'h400;
    steps(1);
    rst8 = 1; bus8.valid = 1;
    steps(2); chk("w8_movB",  32'(b8), 32'hFF);
    steps(2); chk("w8_addB",  32'(b8), 0);
              chk("w8_addBc", 32'(c8), 1);
    steps(2); chk("w8_jmp",   32'(bus8.addr), 32'hA5);
              chk("w8_jmpc",  32'(c8), 0);
    steps(2); chk("w8_jmpFF", 32'(bus8.addr), 32'hFF);
    steps(2); chk("w8_wrap",  32'(bus8.addr), 0);
              chk("w8_movBA", 32'(b8), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
